imm_extend_pipe: RTL and testbench

Parametrised, pipelined immediate-extension unit. It generalises the fixed 16->32 zero-fill extender to any input/output width and four extension modes. A valid/ready handshake on both sides and an output FIFO let it sit between instruction decode and the ALU operand mux under back-pressure.

---
 rtl/imm_extend_pipe_pkg.sv | 27 ++
 rtl/imm_extend_pipe_if.sv | 38 +++
 rtl/imm_extend_pipe_core.sv | 38 +++
 rtl/imm_extend_pipe.sv | 104 ++++++++++
 tb/tb_imm_extend_pipe.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_extend_pipe_pkg.sv
// -----------------------------------------------------------------------------
// imm_ext_defs : shared definitions for the immediate-extension pipeline.
//   - Extension mode encodings (MODE_*) and the mode type.
//   - Default input/output/FIFO sizes.
//   - FIFO occupancy states used by the handshake logic.
// No ports (package).
// -----------------------------------------------------------------------------
package imm_ext_defs;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_ZERO   = 2'b00;  // {zeros, In}
   localparam mode_t MODE_SIGN   = 2'b01;  // {sign, In}
   localparam mode_t MODE_UPPER  = 2'b10;  // {In, zeros}
   localparam mode_t MODE_BRANCH = 2'b11;  // sign-extended In << 2

   localparam int DEF_IN_W  = 16;
   localparam int DEF_OUT_W = 32;
   localparam int DEF_DEPTH = 2;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } fifo_state_t;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe_if : producer/consumer bundle for imm_extend_pipe.
//   In, Mode, In_valid, In_ready      : input-side handshake
//   Out, Out_mode, Out_valid, Out_ready : output-side handshake (FIFO head)
//   Level                             : FIFO occupancy
// Modports: master = environment (drives In side, consumes Out side),
//           slave  = the extension unit.
// -----------------------------------------------------------------------------
interface imm_extend_pipe_if
   import imm_ext_defs::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int OUT_W = DEF_OUT_W,
   parameter int DEPTH = DEF_DEPTH
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic [IN_W-1:0]  In;
   mode_t            Mode;
   logic             In_valid;
   logic             In_ready;
   logic [OUT_W-1:0] Out;
   mode_t            Out_mode;
   logic             Out_valid;
   logic             Out_ready;
   logic [LW-1:0]    Level;

   modport master (
      output In, Mode, In_valid, Out_ready,
      input  In_ready, Out, Out_mode, Out_valid, Level
   );

   modport slave (
      input  In, Mode, In_valid, Out_ready,
      output In_ready, Out, Out_mode, Out_valid, Level
   );

endinterface

// File: rtl/imm_extend_pipe_core.sv
// -----------------------------------------------------------------------------
// imm_ext_core : purely combinational immediate extender.
//   In   [IN_W]  : immediate field
//   Mode [2]     : extension mode (MODE_*)
//   Out  [OUT_W] : extended value
// Requires OUT_W >= IN_W + 2 so the BRANCH shift never drops a bit.
// -----------------------------------------------------------------------------
module imm_ext_core
   import imm_ext_defs::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int OUT_W = DEF_OUT_W
) (
   input  logic [IN_W-1:0]  In,
   input  mode_t            Mode,
   output logic [OUT_W-1:0] Out
);

   localparam int PAD_W = OUT_W - IN_W;

   logic signed [OUT_W-1:0] sext;

   assign sext = {{PAD_W{In[IN_W-1]}}, In};

   always_comb begin
      Out = '0;
      unique case (Mode)
         MODE_ZERO:   Out = {{PAD_W{1'b0}}, In};
         MODE_SIGN:   Out = sext;
         // In lands in the top IN_W bits; the rest of the word is cleared.
         MODE_UPPER:  Out = {In, {PAD_W{1'b0}}};
         // Word offset: the two spare high bits absorb the shift.
         MODE_BRANCH: Out = sext <<< 2;
         default:     Out = '0;
      endcase
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe : immediate extender feeding a small output FIFO.
//   Clk : clock, rising edge
//   Rst : synchronous active-high reset (flushes the FIFO)
//   bus : imm_extend_pipe_if.slave
//         In/Mode/In_valid -> In_ready       (accept when both high)
//         Out/Out_mode/Out_valid <- Out_ready (pop when both high)
//         Level : FIFO occupancy
// The extended value is written straight into the FIFO tail on accept, so a
// result accepted into an empty FIFO is visible the following cycle.
// -----------------------------------------------------------------------------
module imm_extend_pipe
   import imm_ext_defs::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int OUT_W = DEF_OUT_W,
   parameter int DEPTH = DEF_DEPTH
) (
   input logic             Clk,
   input logic             Rst,
   imm_extend_pipe_if.slave bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int EW = OUT_W + 2;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   if (OUT_W < IN_W + 2) begin : g_bad_width
      $error("imm_extend_pipe: OUT_W must be at least IN_W + 2");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("imm_extend_pipe: DEPTH must be a power of 2 and at least 2");
   end

   logic [OUT_W-1:0] ext_p0;
   logic [EW-1:0]    mem [DEPTH];
   logic [EW-1:0]    head;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [LW-1:0]    level;
   fifo_state_t      state;
   logic             push;
   logic             pop;

   imm_ext_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .In   (bus.In),
      .Mode (bus.Mode),
      .Out  (ext_p0)
   );

   // Occupancy state is a pure function of level; no separate register.
   always_comb begin
      state = ST_EMPTY;
      if (level == FULL_LVL) begin
         state = ST_FULL;
      end else if (level != '0) begin
         state = ST_PARTIAL;
      end
   end

   // In_ready depends only on Rst and stored occupancy, never on Out_ready.
   assign bus.In_ready  = !Rst && (state != ST_FULL);
   assign bus.Out_valid = (state != ST_EMPTY);
   assign push          = bus.In_valid && bus.In_ready;
   assign pop           = bus.Out_valid && bus.Out_ready;

   // Stage p0 -> FIFO: extended value and its mode stored together.
   always_ff @(posedge Clk) begin
      if (push) begin
         mem[wr_ptr] <= {bus.Mode, ext_p0};
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            level <= level + LW'(1);
         end else if (pop && !push) begin
            level <= level - LW'(1);
         end
      end
   end

   // Storage is not reset, so an empty FIFO presents zeros rather than stale data.
   assign head         = mem[rd_ptr];
   assign bus.Out      = bus.Out_valid ? head[OUT_W-1:0] : '0;
   assign bus.Out_mode = bus.Out_valid ? head[EW-1:OUT_W] : MODE_ZERO;
   assign bus.Level    = level;

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;
   import imm_ext_defs::*;

   localparam int IW  = 16;
   localparam int OW  = 32;
   localparam int D   = 2;
   localparam int IW8 = 8;
   localparam int OW8 = 16;

   typedef struct packed {
      logic [1:0]  m;
      logic [63:0] v;
   } exp_t;

   logic Clk = 1'b0;
   logic Rst = 1'b1;
   always #5 Clk = ~Clk;

   imm_extend_pipe_if #(.IN_W(IW),  .OUT_W(OW),  .DEPTH(D)) bus ();
   imm_extend_pipe_if #(.IN_W(IW8), .OUT_W(OW8), .DEPTH(D)) bus8 ();

   imm_extend_pipe #(.IN_W(IW), .OUT_W(OW), .DEPTH(D)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   imm_extend_pipe #(.IN_W(IW8), .OUT_W(OW8), .DEPTH(D)) dut8 (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus8)
   );

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t q[$];
   exp_t q8[$];
   exp_t e_m;
   exp_t e_m8;
   logic ready_force = 1'b0;
   logic rand_ready  = 1'b0;
   logic rnd_ready   = 1'b0;
   logic bp_done     = 1'b0;

   assign bus.Out_ready  = rand_ready ? rnd_ready : ready_force;
   assign bus8.Out_ready = 1'b1;

   always @(posedge Clk) begin
      #1 rnd_ready = 1'($urandom_range(0, 1));
   end

   // Reference: extension computed as integer arithmetic on the immediate value.
   function automatic logic [63:0] ref_ext(input int iw, input int ow,
                                           input longint in, input int mode);
      longint msk, s, r;
      msk = (longint'(1) << ow) - 1;
      s   = (in >= (longint'(1) << (iw - 1))) ? in - (longint'(1) << iw) : in;
      case (mode)
         0:       r = in;
         1:       r = s;
         2:       r = in * (longint'(1) << (ow - iw));
         default: r = s * 4;
      endcase
      return 64'(r & msk);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Scoreboard for the 16->32 instance.
   always @(negedge Clk) begin
      if (Rst) begin
         q.delete();
      end else begin
         if (bus.In_valid && bus.In_ready) begin
            e_m.m = bus.Mode;
            e_m.v = ref_ext(IW, OW, longint'(bus.In), int'(bus.Mode));
            q.push_back(e_m);
         end
         if (bus.Out_valid && bus.Out_ready) begin
            if (q.size() == 0) begin
               n_checks++;
               $display("FAIL out_unexpected: got %h with nothing pending", bus.Out);
            end else begin
               e_m = q.pop_front();
               chk("out_val", 64'(bus.Out), e_m.v);
               chk("out_mode", 64'(bus.Out_mode), 64'(e_m.m));
            end
         end
         n_checks++;
         if (int'(bus.Level) <= D) n_pass++;
         else $display("FAIL level_bound: got %0d max %0d", bus.Level, D);
      end
   end

   // Scoreboard for the 8->16 instance.
   always @(negedge Clk) begin
      if (Rst) begin
         q8.delete();
      end else begin
         if (bus8.In_valid && bus8.In_ready) begin
            e_m8.m = bus8.Mode;
            e_m8.v = ref_ext(IW8, OW8, longint'(bus8.In), int'(bus8.Mode));
            q8.push_back(e_m8);
         end
         if (bus8.Out_valid && bus8.Out_ready) begin
            if (q8.size() == 0) begin
               n_checks++;
               $display("FAIL out8_unexpected: got %h with nothing pending", bus8.Out);
            end else begin
               e_m8 = q8.pop_front();
               chk("out8_val", 64'(bus8.Out), e_m8.v);
               chk("out8_mode", 64'(bus8.Out_mode), 64'(e_m8.m));
            end
         end
      end
   end

   task automatic send(input logic [IW-1:0] d, input mode_t m);
      int n = 0;
      bus.In       = d;
      bus.Mode     = m;
      bus.In_valid = 1'b1;
      @(negedge Clk);
      while (!bus.In_ready && n < 200) begin
         @(negedge Clk);
         n++;
      end
      if (!bus.In_ready) begin
         n_checks++;
         $display("FAIL send_timeout: In_ready stuck at %b, required 1", bus.In_ready);
      end
      @(posedge Clk);
      #1 bus.In_valid = 1'b0;
   endtask

   task automatic send8(input logic [IW8-1:0] d, input mode_t m);
      int n = 0;
      bus8.In       = d;
      bus8.Mode     = m;
      bus8.In_valid = 1'b1;
      @(negedge Clk);
      while (!bus8.In_ready && n < 200) begin
         @(negedge Clk);
         n++;
      end
      if (!bus8.In_ready) begin
         n_checks++;
         $display("FAIL send8_timeout: In_ready stuck at %b, required 1", bus8.In_ready);
      end
      @(posedge Clk);
      #1 bus8.In_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((bus.Out_valid || bus8.Out_valid) && n < 100) begin
         @(posedge Clk);
         #1;
         n++;
      end
      chk("drain_done", 64'(bus.Out_valid | bus8.Out_valid), 64'(0));
   endtask

   initial begin
      bus.In = '0;  bus.Mode = MODE_ZERO;  bus.In_valid = 1'b0;
      bus8.In = '0; bus8.Mode = MODE_ZERO; bus8.In_valid = 1'b0;

      // Reset state
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_in_ready", 64'(bus.In_ready), 64'(0));
      chk("rst_level", 64'(bus.Level), 64'(0));
      chk("rst_out_valid", 64'(bus.Out_valid), 64'(0));
      chk("rst_out", 64'(bus.Out), 64'(0));
      Rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 64'(bus.In_ready), 64'(1));

      // Directed modes with Out_ready high
      ready_force = 1'b1;
      send(16'hdcab, MODE_ZERO);
      chk("zero_valid", 64'(bus.Out_valid), 64'(1));
      chk("zero_out", 64'(bus.Out), 64'h0000dcab);
      chk("zero_level", 64'(bus.Level), 64'(1));
      @(posedge Clk);
      #1;
      send(16'hdcab, MODE_SIGN);
      chk("sign_out", 64'(bus.Out), 64'hffffdcab);
      send(16'h0123, MODE_UPPER);
      chk("upper_out", 64'(bus.Out), 64'h01230000);
      send(16'hfffe, MODE_BRANCH);
      chk("branch_neg", 64'(bus.Out), 64'hfffffff8);
      send(16'h0004, MODE_BRANCH);
      chk("branch_pos", 64'(bus.Out), 64'h00000010);
      drain();

      // Back-pressure: third item must stall with the FIFO full
      ready_force = 1'b0;
      fork
         begin
            send(16'h0001, MODE_ZERO);
            send(16'h0002, MODE_ZERO);
            send(16'h0003, MODE_ZERO);
            bp_done = 1'b1;
         end
      join_none
      repeat (4) @(posedge Clk);
      #1;
      chk("bp_level", 64'(bus.Level), 64'(2));
      chk("bp_in_ready", 64'(bus.In_ready), 64'(0));
      chk("bp_head", 64'(bus.Out), 64'h1);
      ready_force = 1'b1;
      for (int i = 0; i < 50 && !bp_done; i++) @(posedge Clk);
      #1;
      chk("bp_done", 64'(bp_done), 64'(1));
      drain();

      // Simultaneous push/pop at Level 1
      ready_force = 1'b0;
      send(16'h00a0, MODE_ZERO);
      ready_force = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         send(16'(16'h00a0 + i), mode_t'(i % 4));
         chk("pp_level", 64'(bus.Level), 64'(1));
      end
      drain();

      // Reset mid-stream with two entries held
      ready_force = 1'b0;
      send(16'h1111, MODE_ZERO);
      send(16'h2222, MODE_SIGN);
      chk("pre_rst_level", 64'(bus.Level), 64'(2));
      Rst = 1'b1;
      #1;
      chk("rst_mid_in_ready", 64'(bus.In_ready), 64'(0));
      @(posedge Clk);
      #1;
      chk("rst_mid_level", 64'(bus.Level), 64'(0));
      chk("rst_mid_valid", 64'(bus.Out_valid), 64'(0));
      chk("rst_mid_out", 64'(bus.Out), 64'(0));
      chk("rst_mid_mode", 64'(bus.Out_mode), 64'(0));
      Rst = 1'b0;
      #1;
      chk("rst_mid_in_ready_after", 64'(bus.In_ready), 64'(1));
      ready_force = 1'b1;

      // Random traffic with random consumer stalls
      rand_ready = 1'b1;
      repeat (300) begin
         send(16'($urandom), mode_t'($urandom_range(0, 3)));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge Clk);
         #1;
      end
      rand_ready  = 1'b0;
      ready_force = 1'b1;
      drain();

      // 8 -> 16 instance
      send8(8'h80, MODE_SIGN);
      chk("w8_sign", 64'(bus8.Out), 64'hff80);
      send8(8'h12, MODE_UPPER);
      chk("w8_upper", 64'(bus8.Out), 64'h1200);
      repeat (40) send8(8'($urandom), mode_t'($urandom_range(0, 3)));
      drain();

      chk("sb_empty", 64'(q.size()), 64'(0));
      chk("sb8_empty", 64'(q8.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
